fetch_ctrl: RTL and testbench

- Sequences the instruction-fetch stage of the 16-bit MIPS pipeline.
- Owns the program-counter register that drives the fetch stage's `prog_count` input, and consumes that stage's `instr_out` and `post_inc_pc`.
- Selects the next PC from three sources: sequential, redirect (branch/jump) or hold.
- Owns the IF/ID pipeline register and its valid bit, honouring hazard stalls, instruction-memory wait states and flushes.

---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_ctrl_if_id_reg.sv | 58 +++++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction-fetch sequencer.
// State encoding, default vectors and the PC increment shared with the
// fetch-stage adder.
package fetch_ctrl_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STALL = 2'd3
  } fetch_state_e;

  // Default PC after reset
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  // Default PC loaded on a misaligned redirect (alignment-trap builds only)
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;
  // Sequential increment; the fetch-stage adder uses the same value
  localparam logic [31:0] INC_VAL       = 32'h0000_0004;

  // True when the two low address bits do not describe a word boundary
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if_id_reg.sv
// fetch_ctrl_if_id_reg: IF/ID pipeline register.
// load   : capture a new instruction and its post-increment PC, mark valid.
// bubble : clear the valid bit only (data fields keep their last value).
// neither: hold everything (used for hazard stalls).
module fetch_ctrl_if_id_reg
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc4,
  output logic              if_valid
);

  logic [31:0]       instr_d, instr_q;
  logic [ADDR_W-1:0] pc4_d,   pc4_q;
  logic              valid_d, valid_q;

  // Next-value selection: load has priority over bubble, otherwise hold
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end else if (bubble) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // IF/ID storage, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0000_0000;
      pc4_q   <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign if_instr = instr_q;
  assign if_pc4   = pc4_q;
  assign if_valid = valid_q;

endmodule : fetch_ctrl_if_id_reg

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 16-bit MIPS pipeline.
// Owns the fetch PC and the IF/ID register. Next PC is sequential
// (post_inc_pc from the fetch-stage adder), redirect, or hold.
// Optional feature macro: FETCH_ALIGN_TRAP_EN -- a misaligned redirect
// loads TRAP_VEC and pulses trap_out; without it the target's low two
// bits are forced to zero and trap_out stays 0.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(TRAP_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [ADDR_W-1:0] post_inc_pc,
  input  logic [31:0]       instr_in,
  input  logic              imem_ready,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc4,
  output logic              if_valid,
  output logic              trap_out
);

`ifdef FETCH_ALIGN_TRAP_EN
  localparam logic ALIGN_TRAP_EN = 1'b1;
`else
  localparam logic ALIGN_TRAP_EN = 1'b0;
`endif

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d,    pc_q;
  logic              trap_d,  trap_q;

  logic              ifid_load_s;
  logic              ifid_bubble_s;
  logic              target_misaligned_s;
  logic [ADDR_W-1:0] target_aligned_s;

  assign target_misaligned_s = addr_misaligned(redirect_target[1:0]);
  assign target_aligned_s    = {redirect_target[ADDR_W-1:2], 2'b00};

  // Next-state, next-PC and IF/ID control, in the priority order:
  // redirect (not in BOOT) > boot idle > stall > imem wait > sequential fetch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    trap_d        = 1'b0;
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // One idle cycle after reset release; redirects are ignored here
        state_d = ST_RUN;
      end
      ST_RUN, ST_WAIT, ST_STALL: begin
        if (redirect_valid) begin
          // Flush wins over stall and wait; costs one bubble
          ifid_bubble_s = 1'b1;
          state_d       = ST_RUN;
          if (ALIGN_TRAP_EN && target_misaligned_s) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end else begin
            pc_d   = target_aligned_s;
            trap_d = 1'b0;
          end
        end else if (stall_in) begin
          // Hold PC and IF/ID untouched (not bubbled)
          state_d = ST_STALL;
        end else if (!imem_ready) begin
          // Memory not ready: keep PC, insert a bubble
          ifid_bubble_s = 1'b1;
          state_d       = ST_WAIT;
        end else begin
          // Normal fetch: capture instruction, advance PC
          ifid_load_s = 1'b1;
          pc_d        = post_inc_pc;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  // FSM state, PC and trap pulse registers; reset aborts immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
    end
  end

  assign pc_out   = pc_q;
  assign trap_out = trap_q;

  fetch_ctrl_if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load_s),
    .bubble   (ifid_bubble_s),
    .instr_in (instr_in),
    .pc4_in   (post_inc_pc),
    .if_instr (if_instr),
    .if_pc4   (if_pc4),
    .if_valid (if_valid)
  );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test-plan scenarios followed by randomized traffic,
// all checked against a behavioural model of the fetch sequencing rules.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] post_inc_pc;
  logic [31:0] instr_in;
  logic        imem_ready;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        trap_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_booted;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_trap;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_out          (pc_out),
    .post_inc_pc     (post_inc_pc),
    .instr_in        (instr_in),
    .imem_ready      (imem_ready),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_instr        (if_instr),
    .if_pc4          (if_pc4),
    .if_valid        (if_valid),
    .trap_out        (trap_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = 32'h0000_0000;
    m_instr  = 32'h0000_0000;
    m_pc4    = 32'h0000_0000;
    m_valid  = 1'b0;
    m_trap   = 1'b0;
  endtask

  // One rising edge of the fetch rules, using the currently driven inputs
  task automatic model_edge();
    m_trap = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (redirect_valid) begin
      m_valid = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
      if (redirect_target % 4 != 0) begin
        m_pc   = 32'h0000_0080;
        m_trap = 1'b1;
      end else begin
        m_pc = redirect_target;
      end
`else
      m_pc = redirect_target - (redirect_target % 4);
`endif
    end else if (stall_in) begin
      // everything held
    end else if (!imem_ready) begin
      m_valid = 1'b0;
    end else begin
      m_instr = instr_in;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},    pc_out,          m_pc);
    check_eq({tag, ".instr"}, if_instr,        m_instr);
    check_eq({tag, ".pc4"},   if_pc4,          m_pc4);
    check_eq({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    check_eq({tag, ".trap"},  {31'd0, trap_out}, {31'd0, m_trap});
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare
  task automatic cycle(input string tag, input bit rdv, input logic [31:0] tgt,
                       input bit stl, input bit rdy, input logic [31:0] ins);
    redirect_valid  = rdv;
    redirect_target = tgt;
    stall_in        = stl;
    imem_ready      = rdy;
    instr_in        = ins;
    post_inc_pc     = m_pc + 32'd4;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0000_0000;
    stall_in        = 1'b0;
    imem_ready      = 1'b1;
    instr_in        = 32'hA0A0_0001;
    post_inc_pc     = 32'h0000_0004;
    model_reset();

    // Reset values
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Boot idle cycle, then first fetch
    cycle("boot", 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0A0_0001);
    check_eq("tp_boot_pc", pc_out, 32'h0000_0000);
    cycle("fetch0", 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0A0_0001);
    check_eq("tp_f0_pc", pc_out, 32'h0000_0004);
    check_eq("tp_f0_instr", if_instr, 32'hA0A0_0001);
    check_eq("tp_f0_pc4", if_pc4, 32'h0000_0004);
    check_eq("tp_f0_valid", {31'd0, if_valid}, 32'd1);
    cycle("fetch1", 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);

    // Wait states at PC=8
    for (int i = 0; i < 3; i++) begin
      cycle("wait", 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_0000);
      check_eq("tp_wait_pc", pc_out, 32'h0000_0008);
      check_eq("tp_wait_valid", {31'd0, if_valid}, 32'd0);
    end
    cycle("resume", 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_4444);
    check_eq("tp_resume_pc", pc_out, 32'h0000_000C);
    cycle("pre_stall", 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_6666);
    check_eq("tp_prestall_pc4", if_pc4, 32'h0000_0010);

    // Stall for two cycles, with memory also not ready on one of them
    cycle("stall0", 1'b0, 32'h0, 1'b1, 1'b1, 32'h7777_8888);
    cycle("stall1", 1'b0, 32'h0, 1'b1, 1'b0, 32'h9999_AAAA);
    check_eq("tp_stall_instr", if_instr, 32'h5555_6666);
    check_eq("tp_stall_valid", {31'd0, if_valid}, 32'd1);

    // Redirect while stalled: redirect wins
    cycle("redir", 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'hBBBB_CCCC);
    check_eq("tp_redir_pc", pc_out, 32'h0000_0200);
    check_eq("tp_redir_valid", {31'd0, if_valid}, 32'd0);
    cycle("redir_st", 1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB_CCCC);
    cycle("redir_f", 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001);
    check_eq("tp_redir_pc4", if_pc4, 32'h0000_0204);

    // Misaligned redirect
    cycle("misal", 1'b1, 32'h0000_0102, 1'b0, 1'b1, 32'h0);
`ifdef FETCH_ALIGN_TRAP_EN
    check_eq("tp_misal_pc", pc_out, 32'h0000_0080);
    check_eq("tp_misal_trap", {31'd0, trap_out}, 32'd1);
`else
    check_eq("tp_misal_pc", pc_out, 32'h0000_0100);
    check_eq("tp_misal_trap", {31'd0, trap_out}, 32'd0);
`endif
    cycle("misal_after", 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

    // Wrap at the top of the address space
    cycle("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
    cycle("wrap", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
    check_eq("tp_wrap_pc", pc_out, 32'h0000_0000);
    check_eq("tp_wrap_pc4", if_pc4, 32'h0000_0000);

    // Asynchronous reset in the middle of WAIT
    cycle("w_pre", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    // BOOT ignores redirect and loads nothing
    cycle("boot_redir", 1'b1, 32'h0000_0400, 1'b0, 1'b1, 32'h0);
    check_eq("tp_boot_redir_pc", pc_out, 32'h0000_0000);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tgt;
      tgt = $urandom();
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(199) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle("rnd", ($urandom_range(9) == 0), tgt, ($urandom_range(4) == 0),
            ($urandom_range(3) != 0), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_ctrl
